counter_input_cond: RTL and testbench

COUNTER_INPUT_COND -- requirements
Module: counter_input_cond

---
 rtl/counter_input_cond.sv | 145 ++++++++++++++
 tb/tb_counter_input_cond.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_input_cond.sv
// counter_input_cond: conditions an asynchronous field input for an event counter.
// raw_in is synchronised, optionally debounced, edge-qualified per edge_sel and
// the resulting events are queued (up to 15) as count pulses for a downstream
// counter that accepts them with a valid/ready handshake.
// Build option: define CIC_DEBOUNCE_EN to enable the filt_len debounce filter;
// without it every level change of the synchronised input commits immediately.
module counter_input_cond (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    input  logic [7:0] filt_len,
    input  logic [1:0] edge_sel,
    input  logic       cnt_ready,
    input  logic       ovf_clr,
    output logic       cnt_valid,
    output logic       filt_out,
    output logic [3:0] pend,
    output logic       ovf
);

    logic       sync_1;
    logic       sync_in;
    logic       mismatch;
    logic       commit;
    logic       event_hit;
    logic       handshake;
    logic       pend_full;
    logic [3:0] pend_nxt;

    // Two-flop synchroniser for the asynchronous field input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1  <= 1'b0;
            sync_in <= 1'b0;
        end else begin
            sync_1  <= raw_in;
            sync_in <= sync_1;
        end
    end

    assign mismatch = (sync_in != filt_out);

`ifdef CIC_DEBOUNCE_EN
    typedef enum logic {STABLE, QUALIFY} state_t;

    state_t     state;
    logic [7:0] deb_cnt;

    // deb_cnt counts mismatching cycles already seen; a live filt_len change
    // is honoured immediately because the compare uses the current value.
    assign commit = mismatch &&
                    ((state == QUALIFY) ? (deb_cnt >= filt_len) : (filt_len == 8'd0));

    // Debounce FSM: a level must persist for filt_len+1 cycles to be committed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= STABLE;
            deb_cnt  <= 8'd0;
            filt_out <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (mismatch) begin
                        if (commit) begin
                            filt_out <= ~filt_out;
                        end else begin
                            state   <= QUALIFY;
                            deb_cnt <= 8'd1;
                        end
                    end
                end
                QUALIFY: begin
                    if (!mismatch) begin
                        state   <= STABLE;
                        deb_cnt <= 8'd0;
                    end else if (commit) begin
                        filt_out <= ~filt_out;
                        state    <= STABLE;
                        deb_cnt  <= 8'd0;
                    end else begin
                        deb_cnt <= deb_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= STABLE;
                    deb_cnt <= 8'd0;
                end
            endcase
        end
    end
`else
    // Filter length is meaningless without the debounce stage
    logic unused_filt_len;
    assign unused_filt_len = ^filt_len;

    assign commit = mismatch;

    // Without debounce the filtered level simply follows the synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_out <= 1'b0;
        end else if (commit) begin
            filt_out <= ~filt_out;
        end
    end
`endif

    // Old filt_out low means this commit is a rising transition
    assign event_hit = commit && (filt_out ? edge_sel[1] : edge_sel[0]);
    assign handshake = cnt_valid && cnt_ready;
    assign pend_full = (pend == 4'd15);

    // Next pending count: saturates at 15, never underflows (handshake needs valid)
    always_comb begin
        pend_nxt = pend;
        if (event_hit && !handshake && !pend_full) begin
            pend_nxt = pend + 4'd1;
        end else if (handshake && !event_hit) begin
            pend_nxt = pend - 4'd1;
        end
    end

    // Pending-pulse queue depth with registered valid derived from the next depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= 4'd0;
            cnt_valid <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            cnt_valid <= (pend_nxt != 4'd0);
        end
    end

    // Sticky overflow: a lost event sets it, and setting beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (event_hit && !handshake && pend_full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_input_cond.sv
// Testbench for counter_input_cond: directed scenarios plus a randomized run,
// all checked against a run-length reference model of the conditioning chain.
module tb_counter_input_cond;

`ifdef CIC_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       raw_in = 1'b0;
    logic [7:0] filt_len = 8'd0;
    logic [1:0] edge_sel = 2'b01;
    logic       cnt_ready = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       cnt_valid;
    logic       filt_out;
    logic [3:0] pend;
    logic       ovf;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    bit m_s1, m_s2, m_filt, m_ovf;
    int m_run, m_pend;

    counter_input_cond dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .filt_len(filt_len),
        .edge_sel(edge_sel), .cnt_ready(cnt_ready), .ovf_clr(ovf_clr),
        .cnt_valid(cnt_valid), .filt_out(filt_out), .pend(pend), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_filt = 0; m_ovf = 0; m_run = 0; m_pend = 0;
    endtask

    // Advance the model by one clock using the present inputs, then clock the DUT.
    // A level is accepted once it has differed from the filtered level for N+1 edges.
    task automatic step();
        bit hs, commit, ev, lost;
        int n;
        n = DEB ? int'(filt_len) : 0;
        hs = (m_pend != 0) && cnt_ready;
        commit = 0;
        if (m_s2 != m_filt) begin
            m_run++;
            if (m_run > n) begin commit = 1; m_run = 0; end
        end else begin
            m_run = 0;
        end
        ev = commit && (m_filt ? edge_sel[1] : edge_sel[0]);
        if (commit) m_filt = !m_filt;
        lost = 0;
        if (ev && !hs) begin
            if (m_pend == 15) lost = 1; else m_pend++;
        end else if (hs && !ev) begin
            m_pend--;
        end
        if (lost) m_ovf = 1; else if (ovf_clr) m_ovf = 0;
        m_s2 = m_s1;
        m_s1 = raw_in;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit raw_level);
        @(negedge clk);
        reset = 1'b0;
        raw_in = raw_level;
        cnt_ready = 0; ovf_clr = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        ntests++;
        if ({filt_out, cnt_valid, pend, ovf} !== 7'd0) begin
            nfail++;
            $display("FAIL reset_state: got %b expected 0000000", {filt_out, cnt_valid, pend, ovf});
        end
        // raw_in high across reset release qualifies as an ordinary rising edge
        filt_len = 0; edge_sel = 2'b01;
        do_reset(1'b1);
        repeat (3) step();
        ntests++;
        if (pend !== 4'd1 || filt_out !== 1'b1) begin
            nfail++;
            $display("FAIL reset_release_high: got pend=%0d filt=%b expected pend=1 filt=1", pend, filt_out);
        end
    endtask

    task automatic test_latency();
        int n, ok;
        do_reset(1'b0);
        filt_len = 8'd3; edge_sel = 2'b01; cnt_ready = 1;
        n = DEB ? 3 : 0;
        raw_in = 1;
        ok = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (filt_out !== (i >= 3 + n) || cnt_valid !== (i == 3 + n)) begin
                ok = 0;
                $display("FAIL latency edge %0d: got filt=%b valid=%b expected filt=%b valid=%b",
                         i, filt_out, cnt_valid, (i >= 3 + n), (i == 3 + n));
            end
        end
        ntests++;
        if (!ok) nfail++;
        ntests++;
        if (pend !== 4'd0) begin
            nfail++;
            $display("FAIL latency_pend: got %0d expected 0", pend);
        end
    endtask

    task automatic test_glitch();
        int bad;
        do_reset(1'b0);
        filt_len = 8'd3; edge_sel = 2'b01; cnt_ready = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            raw_in = (i < 3);
            step();
            if (filt_out !== m_filt || pend !== 4'(m_pend)) begin
                bad++;
                $display("FAIL glitch cycle %0d: got filt=%b pend=%0d expected filt=%b pend=%0d",
                         i, filt_out, pend, m_filt, m_pend);
            end
        end
        ntests++;
        if (bad != 0) nfail++;
    endtask

    task automatic test_both_edges();
        do_reset(1'b0);
        filt_len = 0; edge_sel = 2'b11; cnt_ready = 0;
        for (int t = 0; t < 4; t++) begin
            raw_in = ~raw_in;
            repeat (4) step();
        end
        ntests++;
        if (pend !== 4'd4) begin
            nfail++;
            $display("FAIL both_edges_pend: got %0d expected 4", pend);
        end
        cnt_ready = 1;
        repeat (4) step();
        ntests++;
        if (pend !== 4'd0 || cnt_valid !== 1'b0) begin
            nfail++;
            $display("FAIL both_edges_drain: got pend=%0d valid=%b expected pend=0 valid=0", pend, cnt_valid);
        end
        // ready while empty must not underflow
        repeat (3) step();
        ntests++;
        if (pend !== 4'd0) begin
            nfail++;
            $display("FAIL no_underflow: got %0d expected 0", pend);
        end
        cnt_ready = 0;
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        filt_len = 0; edge_sel = 2'b01; cnt_ready = 0;
        for (int t = 0; t < 16; t++) begin
            raw_in = 1; repeat (4) step();
            raw_in = 0; repeat (4) step();
        end
        ntests++;
        if (pend !== 4'd15 || ovf !== 1'b1) begin
            nfail++;
            $display("FAIL overflow: got pend=%0d ovf=%b expected pend=15 ovf=1", pend, ovf);
        end
        ovf_clr = 1; step(); ovf_clr = 0;
        ntests++;
        if (pend !== 4'd15 || ovf !== 1'b0) begin
            nfail++;
            $display("FAIL ovf_clear: got pend=%0d ovf=%b expected pend=15 ovf=0", pend, ovf);
        end
        // a new overflow coinciding with a clear keeps the flag set
        raw_in = 1; step(); step();
        ovf_clr = 1; step(); ovf_clr = 0;
        ntests++;
        if (ovf !== 1'b1) begin
            nfail++;
            $display("FAIL ovf_set_wins: got %b expected 1", ovf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        filt_len = 0; edge_sel = 2'b01; cnt_ready = 0;
        for (int t = 0; t < 2; t++) begin
            raw_in = 1; repeat (4) step();
            raw_in = 0; repeat (4) step();
        end
        ntests++;
        if (pend !== 4'd2) begin
            nfail++;
            $display("FAIL pre_simul_pend: got %0d expected 2", pend);
        end
        // third rising edge lands on edge 3; accept a pulse on that same edge
        raw_in = 1;
        step(); step();
        cnt_ready = 1; step(); cnt_ready = 0;
        ntests++;
        if (pend !== 4'd2 || filt_out !== 1'b1) begin
            nfail++;
            $display("FAIL simul_event_hs: got pend=%0d filt=%b expected pend=2 filt=1", pend, filt_out);
        end
        // mid-qualify asynchronous reset
        filt_len = 8'd5; raw_in = 0;
        repeat (4) step();
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        ntests++;
        if ({filt_out, cnt_valid, pend, ovf} !== 7'd0) begin
            nfail++;
            $display("FAIL async_reset: got %b expected 0000000", {filt_out, cnt_valid, pend, ovf});
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_random();
        int bad;
        do_reset(1'b0);
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) raw_in = ~raw_in;
            if ($urandom_range(0, 49) == 0) filt_len = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 59) == 0) edge_sel = 2'($urandom_range(0, 3));
            cnt_ready = ($urandom_range(0, 5) == 0);
            ovf_clr = ($urandom_range(0, 40) == 0);
            step();
            ntests++;
            if ({filt_out, cnt_valid, pend, ovf} !== {m_filt, (m_pend != 0), 4'(m_pend), m_ovf}) begin
                nfail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cycle %0d: got filt=%b valid=%b pend=%0d ovf=%b expected filt=%b valid=%b pend=%0d ovf=%b",
                             i, filt_out, cnt_valid, pend, ovf, m_filt, (m_pend != 0), m_pend, m_ovf);
            end
        end
        cnt_ready = 0; ovf_clr = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_both_edges();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
